lsq_entry_buffer: RTL and testbench

- Circular load/store queue storage, indexed by ROB tag; sits directly upstream of lsq_forward_unit.
- Records op type, resolved address and store data per in-flight memory instruction.
- Tracks allocation (fill_ptr) and retirement (head_ptr) pointers.
- Produces the registered per-entry address-hit vector and the per-entry op vector that lsq_forward_unit consumes.

---
 rtl/lsq_entry_buffer.sv | 179 +++++++++++++++++
 tb/tb_lsq_entry_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_entry_buffer.sv
// Circular load/store queue entry storage indexed by ROB tag, feeding lsq_forward_unit.
// Optional misaligned-address tracking is enabled with `define LSQ_MISALIGN_CHECK_EN.
`ifndef ROB_SIZE
`define ROB_SIZE 8
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

package lsq_pkg;
    typedef enum logic [1:0] {
        no_mem_op = 2'd0,
        mem_read  = 2'd1,
        mem_write = 2'd2
    } memory_op_t;
endpackage

module lsq_entry_buffer
    import lsq_pkg::*;
#(
    parameter int DEPTH  = `ROB_SIZE,
    parameter int IDX_W  = `ROB_SIZE_WIDTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           alloc_valid,
    input  logic [IDX_W-1:0]               alloc_tag,
    input  memory_op_t                     alloc_op,
    output logic                           alloc_ready,
    output logic                           alloc_err,
    input  logic                           addr_valid,
    input  logic [IDX_W-1:0]               addr_tag,
    input  logic [ADDR_W-1:0]              addr_value,
    input  logic                           data_valid,
    input  logic [IDX_W-1:0]               data_tag,
    input  logic [DATA_W-1:0]              data_value,
    input  logic                           lookup_valid,
    input  logic [IDX_W-1:0]               lookup_tag,
    input  logic [ADDR_W-1:0]              lookup_addr,
    input  logic                           commit_valid,
    input  logic                           flush_valid,
    output logic [DEPTH-1:0]               hit_address_indices,
    output memory_op_t [DEPTH-1:0]         req_op_indices,
    output logic [DEPTH-1:0][DATA_W-1:0]   store_data_indices,
    output logic [DEPTH-1:0]               data_ready_indices,
    output logic [IDX_W-1:0]               lookup_tag_q,
    output logic                           lookup_valid_q,
`ifdef LSQ_MISALIGN_CHECK_EN
    output logic                           misalign_pulse,
    output logic [IDX_W-1:0]               misalign_tag,
`endif
    output logic [IDX_W-1:0]               fill_ptr,
    output logic [IDX_W-1:0]               head_ptr,
    output logic [IDX_W:0]                 count
);

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH-1:0]        addr_vld_q;
    logic [DEPTH-1:0]        data_vld_q;
    logic [DEPTH-1:0]        mis_excl;
    memory_op_t              op_q   [DEPTH];
    logic [ADDR_W-1:2]       addr_q [DEPTH];
    logic [DATA_W-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]        hit_nxt;

    logic alloc_fire, alloc_mis, commit_fire, addr_fire, data_fire;

    assign alloc_ready = (count != (IDX_W+1)'(DEPTH));

    // Flush suppresses every other state update in the same cycle.
    assign alloc_fire  = alloc_valid & alloc_ready & (alloc_tag == fill_ptr) & ~flush_valid;
    assign alloc_mis   = alloc_valid & alloc_ready & (alloc_tag != fill_ptr) & ~flush_valid;
    assign commit_fire = commit_valid & (count != '0) & ~flush_valid;
    assign addr_fire   = addr_valid & valid_q[addr_tag] & ~flush_valid;
    assign data_fire   = data_valid & valid_q[data_tag] & ~flush_valid;

`ifdef LSQ_MISALIGN_CHECK_EN
    logic [DEPTH-1:0] misalign_q;
    assign mis_excl = misalign_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^addr_value[1:0];
    assign mis_excl = '0;
`endif

    always_comb begin
        hit_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_nxt[i] = lookup_valid & valid_q[i] & addr_vld_q[i] & ~mis_excl[i]
                       & (addr_q[i] == lookup_addr[ADDR_W-1:2])
                       & (IDX_W'(i) != lookup_tag);
        end
    end

    always_comb begin
        req_op_indices     = '{default: no_mem_op};
        store_data_indices = '0;
        data_ready_indices = '0;
        for (int i = 0; i < DEPTH; i++) begin
            req_op_indices[i]     = valid_q[i] ? op_q[i] : no_mem_op;
            store_data_indices[i] = data_q[i];
            data_ready_indices[i] = valid_q[i] & data_vld_q[i];
        end
    end

    // Control state: entry flags, pointers, registered lookup result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q             <= '0;
            addr_vld_q          <= '0;
            data_vld_q          <= '0;
            fill_ptr            <= '0;
            head_ptr            <= '0;
            count               <= '0;
            hit_address_indices <= '0;
            lookup_valid_q      <= 1'b0;
            lookup_tag_q        <= '0;
            alloc_err           <= 1'b0;
        end else if (flush_valid) begin
            valid_q             <= '0;
            fill_ptr            <= '0;
            head_ptr            <= '0;
            count               <= '0;
            hit_address_indices <= '0;
            lookup_valid_q      <= 1'b0;
            lookup_tag_q        <= '0;
            alloc_err           <= 1'b0;
        end else begin
            if (addr_fire) addr_vld_q[addr_tag] <= 1'b1;
            if (data_fire) data_vld_q[data_tag] <= 1'b1;
            // Allocation is written last so it overrides a same-tag address/data write.
            if (alloc_fire) begin
                valid_q[alloc_tag]    <= 1'b1;
                addr_vld_q[alloc_tag] <= 1'b0;
                data_vld_q[alloc_tag] <= 1'b0;
            end
            if (commit_fire) valid_q[head_ptr] <= 1'b0;
            fill_ptr <= fill_ptr + IDX_W'(alloc_fire);
            head_ptr <= head_ptr + IDX_W'(commit_fire);
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            hit_address_indices <= hit_nxt;
            lookup_valid_q      <= lookup_valid;
            lookup_tag_q        <= lookup_tag;
            alloc_err           <= alloc_mis;
        end
    end

`ifdef LSQ_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q     <= '0;
            misalign_pulse <= 1'b0;
            misalign_tag   <= '0;
        end else if (flush_valid) begin
            misalign_q     <= '0;
            misalign_pulse <= 1'b0;
        end else begin
            if (addr_fire) misalign_q[addr_tag] <= |addr_value[1:0];
            if (alloc_fire) misalign_q[alloc_tag] <= 1'b0;
            misalign_pulse <= addr_fire & (|addr_value[1:0]);
            misalign_tag   <= addr_tag;
        end
    end
`endif

    // Entry payload: no reset, qualified by the control flags above
    always_ff @(posedge clk) begin
        if (alloc_fire) op_q[alloc_tag]  <= alloc_op;
        if (addr_fire)  addr_q[addr_tag] <= addr_value[ADDR_W-1:2];
        if (data_fire)  data_q[data_tag] <= data_value;
    end

endmodule

// File: tb/tb_lsq_entry_buffer.sv
// Directed bench for lsq_entry_buffer at DEPTH = 8; optional misalign steps under LSQ_MISALIGN_CHECK_EN.
module tb_lsq_entry_buffer;
    import lsq_pkg::*;

    logic                 clk;
    logic                 reset_n;
    logic                 alloc_valid;
    logic [2:0]           alloc_tag;
    memory_op_t           alloc_op;
    logic                 alloc_ready;
    logic                 alloc_err;
    logic                 addr_valid;
    logic [2:0]           addr_tag;
    logic [31:0]          addr_value;
    logic                 data_valid;
    logic [2:0]           data_tag;
    logic [31:0]          data_value;
    logic                 lookup_valid;
    logic [2:0]           lookup_tag;
    logic [31:0]          lookup_addr;
    logic                 commit_valid;
    logic                 flush_valid;
    logic [7:0]           hit_address_indices;
    memory_op_t [7:0]     req_op_indices;
    logic [7:0][31:0]     store_data_indices;
    logic [7:0]           data_ready_indices;
    logic [2:0]           lookup_tag_q;
    logic                 lookup_valid_q;
`ifdef LSQ_MISALIGN_CHECK_EN
    logic                 misalign_pulse;
    logic [2:0]           misalign_tag;
`endif
    logic [2:0]           fill_ptr;
    logic [2:0]           head_ptr;
    logic [3:0]           count;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    lsq_entry_buffer #(.DEPTH(8), .IDX_W(3), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_op(alloc_op),
        .alloc_ready(alloc_ready), .alloc_err(alloc_err),
        .addr_valid(addr_valid), .addr_tag(addr_tag), .addr_value(addr_value),
        .data_valid(data_valid), .data_tag(data_tag), .data_value(data_value),
        .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .lookup_addr(lookup_addr),
        .commit_valid(commit_valid), .flush_valid(flush_valid),
        .hit_address_indices(hit_address_indices), .req_op_indices(req_op_indices),
        .store_data_indices(store_data_indices), .data_ready_indices(data_ready_indices),
        .lookup_tag_q(lookup_tag_q), .lookup_valid_q(lookup_valid_q),
`ifdef LSQ_MISALIGN_CHECK_EN
        .misalign_pulse(misalign_pulse), .misalign_tag(misalign_tag),
`endif
        .fill_ptr(fill_ptr), .head_ptr(head_ptr), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] tag, input memory_op_t op);
        alloc_valid = 1'b1;
        alloc_tag   = tag;
        alloc_op    = op;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic write_addr(input logic [2:0] tag, input logic [31:0] a);
        addr_valid = 1'b1;
        addr_tag   = tag;
        addr_value = a;
        tick();
        addr_valid = 1'b0;
    endtask

    task automatic lookup(input logic [2:0] tag, input logic [31:0] a);
        lookup_valid = 1'b1;
        lookup_tag   = tag;
        lookup_addr  = a;
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic flush();
        flush_valid = 1'b1;
        tick();
        flush_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        alloc_valid = 0; alloc_tag = 0; alloc_op = no_mem_op;
        addr_valid = 0; addr_tag = 0; addr_value = 0;
        data_valid = 0; data_tag = 0; data_value = 0;
        lookup_valid = 0; lookup_tag = 0; lookup_addr = 0;
        commit_valid = 0; flush_valid = 0;
        repeat (2) tick();

        check("rst_count", count, 0);
        check("rst_fill", fill_ptr, 0);
        check("rst_head", head_ptr, 0);
        check("rst_ready", alloc_ready, 1);
        check("rst_err", alloc_err, 0);
        check("rst_hit", hit_address_indices, 0);
        check("rst_lvq", lookup_valid_q, 0);
        check("rst_ltq", lookup_tag_q, 0);
        check("rst_ops", req_op_indices, 0);
        reset_n = 1'b1;
        tick();

        // Fill all eight entries
        for (int i = 0; i < 8; i++) alloc(3'(i), mem_read);
        check("full_fill_wrap", fill_ptr, 0);
        check("full_count", count, 8);
        check("full_ready", alloc_ready, 0);
        check("full_ops", req_op_indices, 16'h5555);
        alloc(3'd0, mem_write);
        check("full_reject_count", count, 8);
        check("full_reject_err", alloc_err, 0);

        // Commit and alloc together while full: alloc is rejected
        commit_valid = 1'b1;
        alloc_valid = 1'b1; alloc_tag = 3'd0; alloc_op = mem_write;
        tick();
        commit_valid = 1'b0; alloc_valid = 1'b0;
        check("cfull_head", head_ptr, 1);
        check("cfull_count", count, 7);
        check("cfull_fill", fill_ptr, 0);
        check("cfull_op0", req_op_indices[0], no_mem_op);
        alloc(3'd0, mem_write);
        check("realloc_count", count, 8);
        check("realloc_fill", fill_ptr, 1);
        check("realloc_op0", req_op_indices[0], mem_write);

        // Tag mismatch on allocation
        flush();
        check("flush1_count", count, 0);
        alloc(3'd0, mem_read);
        alloc(3'd2, mem_read);
        check("mis_err", alloc_err, 1);
        check("mis_fill", fill_ptr, 1);
        check("mis_op2", req_op_indices[2], no_mem_op);
        check("mis_count", count, 1);
        tick();
        check("mis_err_clear", alloc_err, 0);

        // Address hits
        flush();
        for (int i = 0; i < 4; i++) alloc(3'(i), mem_read);
        for (int i = 4; i < 7; i++) alloc(3'(i), mem_write);
        check("ops_mix", req_op_indices, 16'h2A55);
        for (int i = 3; i < 7; i++) write_addr(3'(i), 32'h100);
        lookup(3'd3, 32'h104);
        check("hit_other_word", hit_address_indices, 8'h00);
        check("hit_lvq", lookup_valid_q, 1);
        lookup(3'd3, 32'h102);
        check("hit_same_word", hit_address_indices, 8'h70);
        check("hit_ltq", lookup_tag_q, 3);
        tick();
        check("hit_idle", hit_address_indices, 8'h00);
        check("hit_idle_lvq", lookup_valid_q, 0);

        // A same-cycle address write is not seen by the lookup
        addr_valid = 1'b1; addr_tag = 3'd2; addr_value = 32'h100;
        lookup(3'd3, 32'h100);
        addr_valid = 1'b0;
        check("hit_preedge", hit_address_indices, 8'h70);
        lookup(3'd3, 32'h100);
        check("hit_postwrite", hit_address_indices, 8'h74);
        lookup(3'd5, 32'h100);
        check("hit_tag5", hit_address_indices, 8'h5C);

        // Store data, including a write to an unallocated entry
        data_valid = 1'b1; data_tag = 3'd4; data_value = 32'hDEADBEEF;
        tick();
        data_tag = 3'd7; data_value = 32'h12345678;
        tick();
        data_valid = 1'b0;
        check("data4", store_data_indices[4], 32'hDEADBEEF);
        check("data_ready", data_ready_indices, 8'h10);

        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        check("commit_head", head_ptr, 1);
        check("commit_count", count, 6);
        check("commit_ops", req_op_indices, 16'h2A54);

        // Flush wins over a concurrent lookup
        flush_valid = 1'b1;
        lookup(3'd3, 32'h100);
        flush_valid = 1'b0;
        check("flush_hit", hit_address_indices, 8'h00);
        check("flush_lvq", lookup_valid_q, 0);
        check("flush_count", count, 0);
        check("flush_fill", fill_ptr, 0);
        check("flush_head", head_ptr, 0);
        check("flush_ops", req_op_indices, 0);

        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        check("empty_commit_head", head_ptr, 0);
        check("empty_commit_count", count, 0);

`ifdef LSQ_MISALIGN_CHECK_EN
        alloc(3'd0, mem_write);
        alloc(3'd1, mem_write);
        write_addr(3'd1, 32'h103);
        check("mis_pulse", misalign_pulse, 1);
        check("mis_tag", misalign_tag, 1);
        write_addr(3'd0, 32'h100);
        check("mis_pulse_clear", misalign_pulse, 0);
        lookup(3'd3, 32'h100);
        check("mis_excluded", hit_address_indices, 8'h01);
        flush();
`endif

        // Asynchronous reset in the middle of a cycle
        alloc(3'd0, mem_read);
        alloc(3'd1, mem_read);
        check("pre_areset_count", count, 2);
        #2 reset_n = 1'b0;
        #1;
        check("areset_count", count, 0);
        check("areset_fill", fill_ptr, 0);
        check("areset_ops", req_op_indices, 0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
